// File: rtl/simon128_128_top.sv
// Iterative SIMON 128/128 encryptor: one round per clock, key schedule generated on the fly.
// Plaintext/key are captured on the first edge after reset release; the result is held once done_o rises.
module simon128_128_top #(
    parameter int ROUNDS = 68,
    parameter int WORD   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*WORD-1:0]   pt_i,
    input  logic [2*WORD-1:0]   k0_i,
    output logic [2*WORD-1:0]   ct_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_RUN  = 2'd1,
        PH_DONE = 2'd2
    } phase_t;

    // Written in reading order: the leftmost digit is z2[0], so it lands in the MSB here.
    localparam logic [61:0] Z2_SEQ =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [WORD-1:0] KEY_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [6:0]      LAST_RND  = 7'(ROUNDS - 1);

    phase_t          phase_reg;
    logic [WORD-1:0] x_reg, y_reg, ka_reg, kb_reg;
    logic [6:0]      rnd_reg;

    logic [61:0]     z2;
    logic [5:0]      z_idx;
    logic            z_bit;
    logic [WORD-1:0] f_x, tmp_a, tmp_b, x_next, kb_next;

    generate
        for (genvar gi = 0; gi < 62; gi++) begin : g_z2_rev
            assign z2[gi] = Z2_SEQ[61-gi];
        end
    endgenerate

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int s);
        return (v >> s) | (v << (WORD - s));
    endfunction

    always_comb begin
        z_idx   = (rnd_reg >= 7'd62) ? 6'(rnd_reg - 7'd62) : rnd_reg[5:0];
        z_bit   = z2[z_idx];
        f_x     = (rol(x_reg, 1) & rol(x_reg, 8)) ^ rol(x_reg, 2);
        x_next  = y_reg ^ f_x ^ ka_reg;
        tmp_a   = ror(kb_reg, 3);
        tmp_b   = tmp_a ^ ror(tmp_a, 1);
        kb_next = ka_reg ^ tmp_b ^ {{(WORD-1){1'b0}}, z_bit} ^ KEY_CONST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= PH_LOAD;
            x_reg     <= '0;
            y_reg     <= '0;
            ka_reg    <= '0;
            kb_reg    <= '0;
            rnd_reg   <= '0;
        end else begin
            case (phase_reg)
                PH_LOAD: begin
                    x_reg     <= pt_i[2*WORD-1:WORD];
                    y_reg     <= pt_i[WORD-1:0];
                    ka_reg    <= k0_i[WORD-1:0];
                    kb_reg    <= k0_i[2*WORD-1:WORD];
                    rnd_reg   <= '0;
                    phase_reg <= PH_RUN;
                end
                PH_RUN: begin
                    x_reg   <= x_next;
                    y_reg   <= x_reg;
                    ka_reg  <= kb_reg;
                    kb_reg  <= kb_next;
                    rnd_reg <= rnd_reg + 7'd1;
                    if (rnd_reg == LAST_RND)
                        phase_reg <= PH_DONE;
                end
                default: ; // DONE: everything frozen until the next reset
            endcase
        end
    end

    assign ct_o   = {x_reg, y_reg};
    assign done_o = (phase_reg == PH_DONE);

endmodule

// File: tb/tb_simon128_128_top.sv
// Scoreboard bench for simon128_128_top: expected {done,ct} pushed at stimulus time, popped at sample time.
module tb_simon128_128_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] pt_i, k0_i;
    logic [127:0] ct_o;
    logic         done_o;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [128:0] exp_q[$];

    simon128_128_top dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pt_i   (pt_i),
        .k0_i   (k0_i),
        .ct_o   (ct_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    // Reference: full key expansion first, then n rounds of the Feistel.
    function automatic logic [127:0] simon_ref(input logic [127:0] pt, input logic [127:0] key, input int n);
        string       z2s = "10101111011100000011010010011000101000010001111110010110110011";
        logic [63:0] k[68];
        logic [63:0] x, y, t, zc;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            zc = (z2s[i % 62] == "1") ? 64'd1 : 64'd0;
            k[i+2] = ~64'd3 ^ zc ^ k[i] ^ rotl(k[i+1], 61) ^ rotl(k[i+1], 60);
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < n; i++) begin
            t = x;
            x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check_val(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got done=%b ct=%h, expected done=%b ct=%h",
                     tag, obs[128], obs[127:0], exp[128], exp[127:0]);
        end else begin
            $display("ok   %s: done=%b ct=%h", tag, obs[128], obs[127:0]);
        end
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: scoreboard empty, got done=%b ct=%h", tag, done_o, ct_o);
        end else begin
            check_val(tag, {done_o, ct_o}, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pulse reset for one cycle with the given operands, release on a falling edge.
    task automatic restart(input logic [127:0] pt, input logic [127:0] key);
        @(negedge clk);
        rst_n = 1'b0;
        pt_i  = pt;
        k0_i  = key;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] pt, key;

        // Reset held with nonzero inputs
        rst_n = 1'b0;
        pt_i  = rand128() | 128'd1;
        k0_i  = rand128() | 128'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_q.push_back(129'd0);
            pop_check("reset_hold");
        end

        // Standard vector with edge-68/69 timing and hold while inputs toggle
        pt  = 128'h63736564207372656c6c657661727420;
        key = 128'h0f0e0d0c0b0a09080706050403020100;
        exp_q.push_back({1'b0, simon_ref(pt, key, 67)});
        exp_q.push_back({1'b1, 128'h49681b1e1e54fe3f65aa832af84e0bbc});
        for (int i = 0; i < 20; i++)
            exp_q.push_back({1'b1, 128'h49681b1e1e54fe3f65aa832af84e0bbc});
        @(negedge clk);
        pt_i  = pt;
        k0_i  = key;
        rst_n = 1'b1;
        repeat (67) tick();
        tick();
        pop_check("std_edge68");
        tick();
        pop_check("std_edge69");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pt_i = rand128();
            k0_i = rand128();
            tick();
            pop_check("std_hold");
        end

        // Mid-run reset at round 30, then restart with new operands
        restart(rand128(), rand128());
        repeat (31) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(129'd0);
        pop_check("midrun_clear");
        pt  = 128'h74636364616e69656c31322f32303234;
        key = 128'h74636364616e69656c31322f32303234;
        pt_i = pt;
        k0_i = key;
        exp_q.push_back({1'b1, simon_ref(pt, key, 68)});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (69) tick();
        pop_check("midrun_result");

        // z-sequence wrap: rounds 60..67 land on edges 62..69
        pt  = rand128();
        key = rand128();
        for (int e = 62; e <= 69; e++)
            exp_q.push_back({(e == 69) ? 1'b1 : 1'b0, simon_ref(pt, key, e - 1)});
        restart(pt, key);
        repeat (61) tick();
        for (int e = 62; e <= 69; e++) begin
            tick();
            pop_check($sformatf("zwrap_edge%0d", e));
        end

        // All-zero plaintext and key
        exp_q.push_back({1'b1, simon_ref(128'd0, 128'd0, 68)});
        restart(128'd0, 128'd0);
        repeat (69) tick();
        pop_check("all_zero");

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/simon128_128_top.md
Name: simon128_128_top

Overview:
- Iterative SIMON 128/128 block-cipher encryptor: 64-bit words, 2-word key, 68 rounds.
- Computes one round per clock and generates the key schedule on the fly.
- Loads plaintext and key on the first clock after reset release, then runs to completion and holds the ciphertext.
- Used as the top-level crypto core of the SIMON datapath.

Parameters:
- ROUNDS, 68, number of cipher rounds; fixed for 128/128 and must not be overridden.
- WORD, 64, word width n.

Ports:
- clk      input   1    rising-edge clock
- rst_n    input   1    asynchronous active-low reset
- pt_i     input   128  plaintext; x = pt_i[127:64], y = pt_i[63:0]
- k0_i     input   128  key; k[0] = k0_i[63:0], k[1] = k0_i[127:64]
- ct_o     output  128  state register {x,y}; holds the ciphertext once done_o=1
- done_o   output  1    high when all 68 rounds have completed

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): x, y, key regs ka/kb, round counter and phase all clear to 0. ct_o=0, done_o=0.
- Phase LOAD, on the first rising edge with rst_n=1:
  - x <= pt_i[127:64], y <= pt_i[63:0]
  - ka <= k0_i[63:0], kb <= k0_i[127:64]
  - rnd <= 0; phase <= RUN
  - pt_i and k0_i are sampled only at this edge.
- Phase RUN, each rising edge, round i = rnd (0..67):
  - f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x)
  - x <= y ^ f(x) ^ ka; y <= x
  - Key update: tmp = ROR3(kb); tmp = tmp ^ ROR1(tmp).
  - knew = ka ^ tmp ^ z2[i mod 62] ^ 64'hFFFF_FFFF_FFFF_FFFC
  - ka <= kb; kb <= knew.
  - rnd <= rnd+1. When rnd==67, go to DONE after the update.
- z2 sequence, index 0 first: 10101111011100000011010010011000101000010001111110010110110011 (62 bits).
  - Store as a 62-bit constant with bit i = z2[i].
  - z index wraps from 61 to 0 at round 62.
- Phase DONE:
  - All registers frozen; done_o=1; ct_o stable.
  - Stays in DONE until rst_n is asserted; there is no restart without reset.
- Latency: 69 rising edges after rst_n deassertion (1 load + 68 rounds) until ct_o = ciphertext and done_o = 1.
- ct_o always reflects the current {x,y} (intermediate values are visible during RUN). Consumers use done_o or count 69 edges.
- Input changes during RUN or DONE have no effect.
- Reset asserted mid-operation: immediate clear to the reset state. The next deassertion reloads the current pt_i/k0_i and restarts the 69-edge sequence.
- Rotations are within 64 bits. All XOR/AND are 64-bit. There is no carry arithmetic.
- Round counter is 7 bits wide and saturates in DONE.

Test Plan:
- Standard vector: k0_i=0f0e0d0c0b0a0908_0706050403020100, pt_i=63736564207372656c6c657661727420, release reset, wait 69 rising edges -> ct_o=49681b1e1e54fe3f65aa832af84e0bbc, done_o=1.
- Timing: same vector. At edge 68, done_o=0 and ct_o is not the final value. At edge 69, done_o=1 and ct_o is the ciphertext. ct_o stays unchanged for 20 further edges while pt_i/k0_i toggle randomly.
- Reset values: hold rst_n=0 for 5 cycles with nonzero inputs -> ct_o=0, done_o=0 throughout.
- Mid-run reset: assert rst_n at round 30, change inputs to pt=k0=74636364616e69656c31322f32303234, release -> after 69 edges ct_o equals the software reference model for that pair, done_o=1.
- z-sequence wrap: compare ct_o every cycle against a bit-accurate model for rounds 60-67 (z index 61 -> 0 -> 5) using a random key/plaintext -> exact match each cycle.
- All-zero pt/key -> ct_o matches the model after 69 edges. This exercises the constant c and the z2 injection alone.
